// File: rtl/riscv_mc_pkg.sv
// riscv_mc_pkg
// Shared definitions for the RV32I multicycle control unit:
//   - state_e      : 4-bit FSM state encoding (also visible on the debug port)
//   - OP_*         : major opcodes recognised by the decoder
//   - ALU_*        : alu_op encodings handed to the ALU controller
//   - SRCA_*/SRCB_*: ALU operand multiplexer selects
//   - WBSEL_*      : register-file write-back source selects
//   - PCSRC_*      : next-PC source selects
//   - decode_opcode: maps an opcode to the state that follows DECODE
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_FAULT    = 4'd14
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_BRANCH = 3'd1;
  localparam logic [2:0] ALU_RFUNCT = 3'd2;
  localparam logic [2:0] ALU_IFUNCT = 3'd3;
  localparam logic [2:0] ALU_PASSB  = 3'd4;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_RS1   = 2'd1;
  localparam logic [1:0] SRCA_OLDPC = 2'd2;
  localparam logic [1:0] SRCA_ZERO  = 2'd3;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  localparam logic [1:0] WBSEL_ALU = 2'd0;
  localparam logic [1:0] WBSEL_MEM = 2'd1;
  localparam logic [1:0] WBSEL_PC4 = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JALR   = 2'd2;

  // Loads and stores share MEM_ADDR; the split happens one state later.
  // Anything not listed is an illegal instruction and traps to FAULT.
  function automatic state_e decode_opcode(input logic [6:0] op);
    case (op)
      OP_R:               return S_EXEC_R;
      OP_I:               return S_EXEC_I;
      OP_LOAD, OP_STORE:  return S_MEM_ADDR;
      OP_BRANCH:          return S_BRANCH;
      OP_JAL:             return S_JAL;
      OP_JALR:            return S_JALR;
      OP_LUI:             return S_LUI;
      OP_AUIPC:           return S_AUIPC;
      default:            return S_FAULT;
    endcase
  endfunction

endpackage

// File: rtl/riscv_mc_timeout.sv
// riscv_mc_timeout
// Memory wait-cycle counter. Counts cycles in which the FSM is waiting on
// mem_ready and flags the cycle on which the wait budget is used up.
// Ports:
//   i_clk      : core clock
//   i_reset    : synchronous active-high reset
//   i_clear    : return the count to zero (not waiting, or memory answered)
//   i_enable   : a waiting cycle; increments the count
//   o_expired  : this waiting cycle is the MEM_TIMEOUT-th consecutive one
module riscv_mc_timeout #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [TO_W-1:0] r_count;

  // The count holds the number of waiting cycles already completed, so the
  // cycle that sees MEM_TIMEOUT-1 is the last one allowed.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  // A clear in the same cycle means memory answered, which beats the timeout.
  assign o_expired = i_enable && !i_clear && (r_count == TO_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl
// Multicycle control FSM for an RV32I core with a shared instruction/data
// memory. Sequences fetch, decode, execute, memory and write-back, waits on a
// variable-latency mem_ready handshake and traps to a sticky FAULT state on an
// illegal opcode or a memory wait longer than MEM_TIMEOUT cycles.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   opcode/funct3/funct7          : instruction fields from the IR
//   branch_taken                  : datapath comparator result (BRANCH)
//   mem_ready                     : memory completes the current access
//   pc_write, ir_write            : PC / IR (+old-PC) load enables
//   mem_read, mem_write, iord     : memory request and address select
//   reg_write, wb_sel             : register-file write and source
//   alu_src_a, alu_src_b, alu_op  : ALU operand selects and operation class
//   pc_src                        : next-PC source
//   instr_done                    : pulse on the last cycle of an instruction
//   fault                         : sticky illegal-opcode / timeout flag
//   state                         : current FSM state (debug)
// Build option PERF_CNT_EN adds cycle_cnt[63:0] and instret_cnt[63:0].
module riscv_mc_ctrl
  import riscv_mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] wb_sel,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       fault,
  output logic [3:0] state
`ifdef PERF_CNT_EN
  ,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
`endif
);

  state_e r_state;
  state_e w_next;
  logic   w_mem_state;
  logic   w_waiting;
  logic   w_expired;
  logic   w_unused;

  // funct3/funct7 are decoded by the ALU controller, not here.
  assign w_unused = ^{funct3, funct7};

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign w_waiting   = w_mem_state && !mem_ready;

  // Clearing whenever we are not waiting guarantees a zero count on entry to
  // every memory state, and restarts the budget whenever memory answers.
  riscv_mc_timeout #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TO_W        (TO_W)
  ) u_timeout (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_clear   (!w_waiting),
    .i_enable  (w_waiting),
    .o_expired (w_expired)
  );

  // State register: reset always lands in FETCH, even out of FAULT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. Memory states stay put until mem_ready or timeout;
  // FAULT is absorbing and the unused encoding also falls into it.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (mem_ready) w_next = S_DECODE;
                  else if (w_expired) w_next = S_FAULT;
      S_DECODE:   w_next = decode_opcode(opcode);
      S_EXEC_R,
      S_EXEC_I:   w_next = S_WB_ALU;
      S_MEM_ADDR: w_next = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) w_next = S_WB_MEM;
                  else if (w_expired) w_next = S_FAULT;
      S_MEM_WR:   if (mem_ready) w_next = S_FETCH;
                  else if (w_expired) w_next = S_FAULT;
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL,
      S_JALR, S_LUI, S_AUIPC:
                  w_next = S_FETCH;
      S_FAULT:    w_next = S_FAULT;
      default:    w_next = S_FAULT;
    endcase
  end

  // Output logic. Mostly Moore; the mem_ready terms in FETCH/MEM_WR and the
  // branch_taken term in BRANCH are Mealy. Reset forces everything low at
  // once so a pending memory request is withdrawn before the next edge.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;
    wb_sel     = WBSEL_ALU;
    pc_src     = PCSRC_ALU;
    instr_done = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_a = SRCA_PC;
          alu_src_b = SRCB_FOUR;
          alu_op    = ALU_ADD;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = PCSRC_ALU;
          end
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          alu_op    = ALU_ADD;
        end
        S_EXEC_R: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_RS2;
          alu_op    = ALU_RFUNCT;
        end
        S_EXEC_I: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALU_IFUNCT;
        end
        S_MEM_ADDR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALU_ADD;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEM_WR: begin
          mem_write  = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ready;
        end
        S_WB_ALU: begin
          reg_write  = 1'b1;
          wb_sel     = WBSEL_ALU;
          instr_done = 1'b1;
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          wb_sel     = WBSEL_MEM;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = SRCA_RS1;
          alu_src_b  = SRCB_RS2;
          alu_op     = ALU_BRANCH;
          pc_write   = branch_taken;
          pc_src     = PCSRC_ALUOUT;
          instr_done = 1'b1;
        end
        S_JAL: begin
          reg_write  = 1'b1;
          wb_sel     = WBSEL_PC4;
          pc_write   = 1'b1;
          pc_src     = PCSRC_ALUOUT;
          instr_done = 1'b1;
        end
        S_JALR: begin
          alu_src_a  = SRCA_RS1;
          alu_src_b  = SRCB_IMM;
          alu_op     = ALU_ADD;
          pc_write   = 1'b1;
          pc_src     = PCSRC_JALR;
          reg_write  = 1'b1;
          wb_sel     = WBSEL_PC4;
          instr_done = 1'b1;
        end
        S_LUI: begin
          alu_src_a  = SRCA_ZERO;
          alu_src_b  = SRCB_IMM;
          alu_op     = ALU_PASSB;
          reg_write  = 1'b1;
          wb_sel     = WBSEL_ALU;
          instr_done = 1'b1;
        end
        S_AUIPC: begin
          alu_src_a  = SRCA_OLDPC;
          alu_src_b  = SRCB_IMM;
          alu_op     = ALU_ADD;
          reg_write  = 1'b1;
          wb_sel     = WBSEL_ALU;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign fault = !reset && (r_state == S_FAULT);
  assign state = r_state;

`ifdef PERF_CNT_EN
  logic [63:0] r_cycle_cnt;
  logic [63:0] r_instret_cnt;

  // Free-running counters; FAULT cycles still count as cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 64'd1;
      if (instr_done) begin
        r_instret_cnt <= r_instret_cnt + 64'd1;
      end
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`endif

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// tb_riscv_mc_ctrl
// Directed testbench for riscv_mc_ctrl built with MEM_TIMEOUT = 4. Each
// driven cycle pushes its hand-computed control vector into a scoreboard
// queue; a separate monitor pops and compares on the following falling edge.
// Vector layout: {pc_write, ir_write, mem_read, mem_write, iord, reg_write,
//                 alu_src_a, alu_src_b, alu_op, wb_sel, pc_src,
//                 instr_done, fault, state}
module tb_riscv_mc_ctrl;

  localparam int TB_TIMEOUT = 4;

  localparam logic [6:0] C_R      = 7'b0110011;
  localparam logic [6:0] C_I      = 7'b0010011;
  localparam logic [6:0] C_LOAD   = 7'b0000011;
  localparam logic [6:0] C_STORE  = 7'b0100011;
  localparam logic [6:0] C_BRANCH = 7'b1100011;
  localparam logic [6:0] C_JAL    = 7'b1101111;
  localparam logic [6:0] C_JALR   = 7'b1100111;
  localparam logic [6:0] C_LUI    = 7'b0110111;
  localparam logic [6:0] C_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_BAD    = 7'b1111111;

  logic        clk;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        branch_taken;
  logic        mem_ready;
  logic        pc_write, ir_write, mem_read, mem_write, iord, reg_write;
  logic [1:0]  alu_src_a, alu_src_b, wb_sel, pc_src;
  logic [2:0]  alu_op;
  logic        instr_done, fault;
  logic [3:0]  state;
`ifdef PERF_CNT_EN
  logic [63:0] cycle_cnt, instret_cnt;
`endif

  typedef struct {
    logic [22:0] exp;
    string       tag;
  } item_t;

  item_t sbq[$];
  int    checks = 0;
  int    errors = 0;

  riscv_mc_ctrl #(.MEM_TIMEOUT(TB_TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7       (funct7),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .ir_write     (ir_write),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .iord         (iord),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .wb_sel       (wb_sel),
    .pc_src       (pc_src),
    .instr_done   (instr_done),
    .fault        (fault),
    .state        (state)
`ifdef PERF_CNT_EN
    ,
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
`endif
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Build a packed expected vector from individual control values.
  function automatic logic [22:0] mk(input logic pcw, input logic irw, input logic mrd,
                                     input logic mwr, input logic io, input logic rw,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [2:0] op, input logic [1:0] wb,
                                     input logic [1:0] ps, input logic done,
                                     input logic flt, input logic [3:0] st);
    return {pcw, irw, mrd, mwr, io, rw, sa, sb, op, wb, ps, done, flt, st};
  endfunction

  // Hand-derived expected outputs per state.
  function automatic logic [22:0] eIdle(input logic [3:0] st);  return mk(0,0,0,0,0,0,0,0,0,0,0,0,0,st); endfunction
  function automatic logic [22:0] eFetch(input logic r);         return mk(r,r,1,0,0,0,0,1,0,0,0,0,0,4'd0); endfunction
  function automatic logic [22:0] eDecode();                     return mk(0,0,0,0,0,0,2,2,0,0,0,0,0,4'd1); endfunction
  function automatic logic [22:0] eExecR();                      return mk(0,0,0,0,0,0,1,0,2,0,0,0,0,4'd2); endfunction
  function automatic logic [22:0] eExecI();                      return mk(0,0,0,0,0,0,1,2,3,0,0,0,0,4'd3); endfunction
  function automatic logic [22:0] eMemAddr();                    return mk(0,0,0,0,0,0,1,2,0,0,0,0,0,4'd4); endfunction
  function automatic logic [22:0] eMemRd();                      return mk(0,0,1,0,1,0,0,0,0,0,0,0,0,4'd5); endfunction
  function automatic logic [22:0] eMemWr(input logic r);         return mk(0,0,0,1,1,0,0,0,0,0,0,r,0,4'd6); endfunction
  function automatic logic [22:0] eWbAlu();                      return mk(0,0,0,0,0,1,0,0,0,0,0,1,0,4'd7); endfunction
  function automatic logic [22:0] eWbMem();                      return mk(0,0,0,0,0,1,0,0,0,1,0,1,0,4'd8); endfunction
  function automatic logic [22:0] eBranch(input logic bt);       return mk(bt,0,0,0,0,0,1,0,1,0,1,1,0,4'd9); endfunction
  function automatic logic [22:0] eJal();                        return mk(1,0,0,0,0,1,0,0,0,2,1,1,0,4'd10); endfunction
  function automatic logic [22:0] eJalr();                       return mk(1,0,0,0,0,1,1,2,0,2,2,1,0,4'd11); endfunction
  function automatic logic [22:0] eLui();                        return mk(0,0,0,0,0,1,3,2,4,0,0,1,0,4'd12); endfunction
  function automatic logic [22:0] eAuipc();                      return mk(0,0,0,0,0,1,2,2,0,0,0,1,0,4'd13); endfunction
  function automatic logic [22:0] eFault();                      return mk(0,0,0,0,0,0,0,0,0,0,0,0,1,4'd14); endfunction

  // Drive one cycle of inputs just after the rising edge and queue the
  // response expected for that cycle.
  task automatic applyStimulus(input logic rst, input logic [6:0] opc, input logic mr,
                               input logic bt, input logic [22:0] exp, input string tag);
    item_t it;
    @(posedge clk);
    #1;
    reset        = rst;
    opcode       = opc;
    mem_ready    = mr;
    branch_taken = bt;
    it.exp = exp;
    it.tag = tag;
    sbq.push_back(it);
  endtask

  task automatic checkOutput(input item_t it);
    logic [22:0] act;
    act = {pc_write, ir_write, mem_read, mem_write, iord, reg_write, alu_src_a,
           alu_src_b, alu_op, wb_sel, pc_src, instr_done, fault, state};
    checks++;
    if (act !== it.exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %b expected %b", it.tag, $time, act, it.exp);
    end
  endtask

  // Monitor: compares the DUT against the oldest queued expectation on each
  // falling edge, well clear of the rising edge where inputs change.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        it = sbq.pop_front();
        checkOutput(it);
      end
    end
  end

  // Hard stop in case the stimulus process ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; opcode = '0; funct3 = 3'b101; funct7 = 7'h20;
    mem_ready = 1'b0; branch_taken = 1'b0;

    applyStimulus(1, C_R, 0, 0, eIdle(4'd0), "reset");

    // add, zero wait states
    applyStimulus(0, C_R, 1, 0, eFetch(1), "add fetch");
    applyStimulus(0, C_R, 1, 0, eDecode(), "add decode");
    applyStimulus(0, C_R, 1, 0, eExecR(),  "add exec");
    applyStimulus(0, C_R, 1, 0, eWbAlu(),  "add wb");

    // addi, with one fetch wait
    applyStimulus(0, C_I, 0, 0, eFetch(0), "addi fetch wait");
    applyStimulus(0, C_I, 1, 0, eFetch(1), "addi fetch");
    applyStimulus(0, C_I, 1, 0, eDecode(), "addi decode");
    applyStimulus(0, C_I, 1, 0, eExecI(),  "addi exec");
    applyStimulus(0, C_I, 1, 0, eWbAlu(),  "addi wb");

    // lw, mem_ready late by 3 cycles: the 4th MEM_RD cycle hits the timeout boundary
    applyStimulus(0, C_LOAD, 1, 0, eFetch(1),  "lw fetch");
    applyStimulus(0, C_LOAD, 1, 0, eDecode(),  "lw decode");
    applyStimulus(0, C_LOAD, 1, 0, eMemAddr(), "lw addr");
    for (int i = 0; i < 3; i++) applyStimulus(0, C_LOAD, 0, 0, eMemRd(), "lw rd wait");
    applyStimulus(0, C_LOAD, 1, 0, eMemRd(),   "lw rd ready");
    applyStimulus(0, C_LOAD, 1, 0, eWbMem(),   "lw wb");

    // sw with one write wait
    applyStimulus(0, C_STORE, 1, 0, eFetch(1),  "sw fetch");
    applyStimulus(0, C_STORE, 1, 0, eDecode(),  "sw decode");
    applyStimulus(0, C_STORE, 1, 0, eMemAddr(), "sw addr");
    applyStimulus(0, C_STORE, 0, 0, eMemWr(0),  "sw wr wait");
    applyStimulus(0, C_STORE, 1, 0, eMemWr(1),  "sw wr done");

    // beq not taken, then taken
    applyStimulus(0, C_BRANCH, 1, 0, eFetch(1),  "beq0 fetch");
    applyStimulus(0, C_BRANCH, 1, 0, eDecode(),  "beq0 decode");
    applyStimulus(0, C_BRANCH, 1, 0, eBranch(0), "beq not taken");
    applyStimulus(0, C_BRANCH, 1, 1, eFetch(1),  "beq1 fetch");
    applyStimulus(0, C_BRANCH, 1, 1, eDecode(),  "beq1 decode");
    applyStimulus(0, C_BRANCH, 1, 1, eBranch(1), "beq taken");

    // jumps and upper-immediate forms
    applyStimulus(0, C_JAL, 1, 0, eFetch(1), "jal fetch");
    applyStimulus(0, C_JAL, 1, 0, eDecode(), "jal decode");
    applyStimulus(0, C_JAL, 1, 0, eJal(),    "jal");
    applyStimulus(0, C_JALR, 1, 0, eFetch(1), "jalr fetch");
    applyStimulus(0, C_JALR, 1, 0, eDecode(), "jalr decode");
    applyStimulus(0, C_JALR, 1, 0, eJalr(),   "jalr");
    applyStimulus(0, C_LUI, 1, 0, eFetch(1), "lui fetch");
    applyStimulus(0, C_LUI, 1, 0, eDecode(), "lui decode");
    applyStimulus(0, C_LUI, 1, 0, eLui(),    "lui");
    applyStimulus(0, C_AUIPC, 1, 0, eFetch(1), "auipc fetch");
    applyStimulus(0, C_AUIPC, 1, 0, eDecode(), "auipc decode");
    applyStimulus(0, C_AUIPC, 1, 0, eAuipc(),  "auipc");

    // mem_ready arrives on the 4th fetch wait cycle: no fault
    for (int i = 0; i < 3; i++) applyStimulus(0, C_R, 0, 0, eFetch(0), "late fetch wait");
    applyStimulus(0, C_R, 1, 0, eFetch(1), "late fetch ready");
    applyStimulus(0, C_R, 1, 0, eDecode(), "late decode");
    applyStimulus(0, C_R, 1, 0, eExecR(),  "late exec");
    applyStimulus(0, C_R, 1, 0, eWbAlu(),  "late wb");

    // fetch never answered: FAULT exactly 4 cycles after FETCH entry
    for (int i = 0; i < 4; i++) applyStimulus(0, C_R, 0, 0, eFetch(0), "timeout fetch wait");
    applyStimulus(0, C_R, 0, 0, eFault(), "timeout fault");
    applyStimulus(0, C_R, 1, 0, eFault(), "timeout fault sticky");
    applyStimulus(1, C_R, 0, 0, eIdle(4'd14), "reset in fault");
    applyStimulus(0, C_R, 1, 0, eFetch(1), "after reset fetch");
    applyStimulus(0, C_R, 1, 0, eDecode(), "after reset decode");
    applyStimulus(0, C_R, 1, 0, eExecR(),  "after reset exec");
    applyStimulus(0, C_R, 1, 0, eWbAlu(),  "after reset wb");

    // illegal opcode: absorbing FAULT for 20 cycles regardless of inputs
    applyStimulus(0, C_BAD, 1, 0, eFetch(1), "bad fetch");
    applyStimulus(0, C_BAD, 1, 0, eDecode(), "bad decode");
    for (int i = 0; i < 20; i++) applyStimulus(0, C_BAD, i[0], 1, eFault(), "illegal fault hold");
    applyStimulus(1, C_BAD, 0, 0, eIdle(4'd14), "reset from illegal");
    applyStimulus(0, C_AUIPC, 1, 0, eFetch(1), "recover fetch");
    applyStimulus(0, C_AUIPC, 1, 0, eDecode(), "recover decode");
    applyStimulus(0, C_AUIPC, 1, 0, eAuipc(),  "recover auipc");

    // store timeout in MEM_WR
    applyStimulus(0, C_STORE, 1, 0, eFetch(1),  "swto fetch");
    applyStimulus(0, C_STORE, 1, 0, eDecode(),  "swto decode");
    applyStimulus(0, C_STORE, 1, 0, eMemAddr(), "swto addr");
    for (int i = 0; i < 4; i++) applyStimulus(0, C_STORE, 0, 0, eMemWr(0), "swto wait");
    applyStimulus(0, C_STORE, 0, 0, eFault(), "swto fault");

    // reset mid-load drops the read request in the same cycle
    applyStimulus(1, C_LOAD, 0, 0, eIdle(4'd14), "reset before load");
    applyStimulus(0, C_LOAD, 1, 0, eFetch(1),  "lwr fetch");
    applyStimulus(0, C_LOAD, 1, 0, eDecode(),  "lwr decode");
    applyStimulus(0, C_LOAD, 1, 0, eMemAddr(), "lwr addr");
    applyStimulus(0, C_LOAD, 0, 0, eMemRd(),   "lwr rd wait");
    applyStimulus(1, C_LOAD, 0, 0, eIdle(4'd5), "reset mid read");

`ifdef PERF_CNT_EN
    // ten zero-wait adds straight after reset
    for (int n = 0; n < 10; n++) begin
      applyStimulus(0, C_R, 1, 0, eFetch(1), "perf fetch");
      applyStimulus(0, C_R, 1, 0, eDecode(), "perf decode");
      applyStimulus(0, C_R, 1, 0, eExecR(),  "perf exec");
      applyStimulus(0, C_R, 1, 0, eWbAlu(),  "perf wb");
    end
    applyStimulus(0, C_R, 1, 0, eFetch(1), "perf next fetch");
    @(negedge clk);
    checks++;
    if (cycle_cnt !== 64'd40) begin
      errors++;
      $display("[TB] FAIL cycle_cnt: got %0d expected 40", cycle_cnt);
    end
    checks++;
    if (instret_cnt !== 64'd10) begin
      errors++;
      $display("[TB] FAIL instret_cnt: got %0d expected 10", instret_cnt);
    end
`else
    applyStimulus(0, C_R, 1, 0, eFetch(1), "post reset fetch");
`endif

    // let the monitor drain the scoreboard, bounded
    for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_mc_ctrl.md
Name: riscv_mc_ctrl

Overview:
Multicycle control unit for the next-generation RV32I core. It replaces single-cycle combinational control with a Moore/Mealy FSM that sequences fetch, decode, execute, memory and writeback over several cycles, and drives a shared-memory datapath. Memory latency is variable: a ready handshake plus a parametrised timeout leads to a sticky fault state.

Parameters:
MEM_TIMEOUT, 16, max wait cycles for mem_ready in any memory state before FAULT; must be ≥1
TO_W, $clog2(MEM_TIMEOUT+1), timeout counter width

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
opcode  in  7  instr[6:0] from IR
funct3  in  3  instr[14:12]
funct7  in  7  instr[31:25]
branch_taken  in  1  datapath comparator result, valid in BRANCH
mem_ready  in  1  memory completes the current read/write this cycle
pc_write  out  1  load PC
ir_write  out  1  load IR (and old-PC register)
mem_read  out  1  memory read request
mem_write  out  1  memory write request
iord  out  1  0 = PC addresses memory; 1 = ALU-out addresses memory
reg_write  out  1  register-file write
alu_src_a  out  2  0 = PC, 1 = rs1, 2 = old-PC, 3 = zero
alu_src_b  out  2  0 = rs2, 1 = const 4, 2 = imm
alu_op  out  3  0 = add, 1 = branch compare, 2 = R-funct, 3 = I-funct, 4 = pass-B
wb_sel  out  2  0 = ALU result, 1 = mem data, 2 = old-PC+4
pc_src  out  2  0 = ALU result, 1 = ALU-out reg, 2 = ALU result with bit0 cleared
instr_done  out  1  one-cycle pulse on the final cycle of each instruction
fault  out  1  sticky illegal-opcode/timeout flag
state  out  4  current state (debug)

Behaviour:
- Reset: state = FETCH, timeout counter = 0, fault = 0. While reset is high, all control outputs are 0.
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JAL, JALR, LUI, AUIPC, FAULT.
- FETCH
  - Drives mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, next state DECODE.
- DECODE: alu_src_a=2, alu_src_b=2, alu_op=0 (precomputes branch target into ALU-out). Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 and 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - any other opcode → FAULT
- EXEC_R: src_a=1, src_b=0, alu_op=2 → WB_ALU.
- EXEC_I: src_a=1, src_b=2, alu_op=3 → WB_ALU.
- WB_ALU: reg_write=1, wb_sel=0, instr_done=1 → FETCH.
- MEM_ADDR: src_a=1, src_b=2, alu_op=0 → MEM_RD if opcode is load, else MEM_WR.
- MEM_RD / MEM_WR: mem_read or mem_write held at 1 with iord=1 until mem_ready. Then MEM_RD → WB_MEM, and MEM_WR → FETCH with instr_done=1.
- WB_MEM: reg_write=1, wb_sel=1, instr_done=1 → FETCH.
- BRANCH: src_a=1, src_b=0, alu_op=1. pc_write = branch_taken (Mealy), pc_src=1, instr_done=1 → FETCH.
- JAL: reg_write=1, wb_sel=2, pc_write=1, pc_src=1, instr_done=1 → FETCH.
- JALR: src_a=1, src_b=2, alu_op=0, pc_write=1, pc_src=2, reg_write=1, wb_sel=2, instr_done=1 → FETCH.
- LUI: src_a=3, src_b=2, alu_op=4, reg_write=1, wb_sel=0, instr_done=1.
- AUIPC: src_a=2, src_b=2, alu_op=0, reg_write=1, wb_sel=0, instr_done=1.
- Latency with zero wait states:
  - 3 cycles: branch, JAL, JALR, LUI, AUIPC
  - 4 cycles: R-type, I-type, store
  - 5 cycles: load
  - Each memory wait cycle adds 1.
- Timeout counter
  - Clears on entry to FETCH, MEM_RD and MEM_WR, and on mem_ready.
  - Increments each waiting cycle.
  - Reaching MEM_TIMEOUT with mem_ready still low → FAULT. mem_ready arriving in the same cycle wins.
- FAULT: all control outputs 0, fault=1, state is absorbing. Only reset exits it.
- Reset mid-operation: the FSM returns to FETCH on the next edge and any pending memory request drops immediately.
- funct3/funct7 are unused internally; alu_op hands decoding to the ALU controller.

Optional Feature:
PERF_CNT_EN
- Defined: adds outputs cycle_cnt[63:0] and instret_cnt[63:0].
  - cycle_cnt increments every non-reset cycle, including FAULT.
  - instret_cnt increments on instr_done.
  - Both clear on reset and wrap at 2^64.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package riscv_mc_pkg holds:
  - state_e enum (4-bit)
  - opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC)
  - alu_op, alu_src and wb_sel encodings
- One natural sub-module, riscv_mc_timeout: wait counter with clear/enable inputs and an expired output.

Test Plan:
- add (0110011) with mem_ready tied 1 → states FETCH, DECODE, EXEC_R, WB_ALU; instr_done on cycle 4; reg_write=1 only in cycle 4.
- lw with mem_ready delayed 3 cycles in MEM_RD → mem_read held 4 cycles with iord=1; instr_done on cycle 8.
- beq with branch_taken=0, then with branch_taken=1 → pc_write in BRANCH is 0, then 1 with pc_src=1; each takes 3 cycles.
- Opcode 1111111 → FAULT after DECODE; fault=1 and all controls 0 for 20 cycles; reset returns the FSM to FETCH with fault=0.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH → FAULT entered exactly 4 cycles after FETCH entry. Repeat with mem_ready=1 on the 4th wait cycle → DECODE, no fault.
- PERF_CNT_EN: 10 zero-wait add instructions → instret_cnt=10, cycle_cnt=40.
